// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding from MEM/WB, load-use stall
// detection and bubble insertion on stall or branch flush.
module ex_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [3:0]  id_alu_op,
  input  logic        id_alu_src,
  input  logic [4:0]  id_wreg,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        flush,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_wreg,
  input  logic [31:0] mem_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_wreg,
  input  logic [31:0] wb_result,
  output logic        stall,
  output logic        ex_valid,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  output logic [3:0]  alu_op,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_wreg,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 4;

  typedef struct packed {
    logic            valid;
    logic [RW-1:0]   rs;
    logic [RW-1:0]   rt;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   shamt;
    logic [OPW-1:0]  alu_op;
    logic            alu_src;
    logic [RW-1:0]   wreg;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
  } ex_reg_t;

  ex_reg_t ex_q;
  ex_reg_t ex_d;
  logic    load_use;
  logic [XLEN-1:0] fwd_rs;
  logic [XLEN-1:0] fwd_rt;

  // Consumer in ID reads the register a load in EX has not yet fetched.
  always_comb begin
    load_use = 1'b0;
    if (id_valid && ex_q.valid && ex_q.mem_read && (ex_q.wreg != RW'(0))) begin
      load_use = (id_uses_rs && (id_rs == ex_q.wreg)) ||
                 (id_uses_rt && (id_rt == ex_q.wreg));
    end
  end

  assign stall = load_use & ~flush;

  // Flush or load-use inserts an all-zero bubble; otherwise capture ID.
  always_comb begin
    ex_d = '0;
    if (!flush && !load_use) begin
      ex_d.valid      = id_valid;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.rs_val     = id_rs_val;
      ex_d.rt_val     = id_rt_val;
      ex_d.imm        = id_imm;
      ex_d.shamt      = id_shamt;
      ex_d.alu_op     = id_alu_op;
      ex_d.alu_src    = id_alu_src;
      ex_d.wreg       = id_wreg;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.mem_to_reg = id_mem_to_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // MEM has priority over WB; register 0 is hardwired and never forwarded.
  always_comb begin
    fwd_rs = ex_q.rs_val;
    if (mem_reg_write && (mem_wreg != RW'(0)) && (mem_wreg == ex_q.rs)) begin
      fwd_rs = mem_result;
    end else if (wb_reg_write && (wb_wreg != RW'(0)) && (wb_wreg == ex_q.rs)) begin
      fwd_rs = wb_result;
    end
  end

  always_comb begin
    fwd_rt = ex_q.rt_val;
    if (mem_reg_write && (mem_wreg != RW'(0)) && (mem_wreg == ex_q.rt)) begin
      fwd_rt = mem_result;
    end else if (wb_reg_write && (wb_wreg != RW'(0)) && (wb_wreg == ex_q.rt)) begin
      fwd_rt = wb_result;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign alu_a         = fwd_rs;
  assign alu_b         = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_shamt     = ex_q.shamt;
  assign alu_op        = ex_q.alu_op;
  assign ex_wreg       = ex_q.wreg;
  assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
  assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
  assign ex_mem_write  = ex_q.valid & ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.valid & ex_q.mem_to_reg;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: a reference model of the ID/EX stage
// checked every cycle, plus literal expectations for the planned scenarios.
module tb_ex_operand_stage;

  logic        clk, rst_n;
  logic        id_valid, id_uses_rs, id_uses_rt, id_alu_src;
  logic [4:0]  id_rs, id_rt, id_shamt, id_wreg;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic [3:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_wreg, wb_wreg;
  logic [31:0] mem_result, wb_result;
  logic        stall, ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  alu_shamt, ex_wreg;
  logic [3:0]  alu_op;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_wreg(id_wreg), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_wreg(mem_wreg), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg), .wb_result(wb_result),
    .stall(stall), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_shamt(alu_shamt), .alu_op(alu_op), .ex_store_data(ex_store_data),
    .ex_wreg(ex_wreg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the EX stage must hold after each edge.
  logic        m_valid, m_src, m_rw, m_mr, m_mw, m_m2r;
  logic [4:0]  m_rs, m_rt, m_shamt, m_wreg;
  logic [31:0] m_rs_val, m_rt_val, m_imm;
  logic [3:0]  m_op;
  logic        started = 1'b0;
  logic        lu_p, lu_n;

  function automatic logic lu_of(input logic v, input logic mr, input logic [4:0] wr);
    return id_valid && v && mr && (wr != 5'd0) &&
           ((id_uses_rs && id_rs == wr) || (id_uses_rt && id_rt == wr));
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
    if (mem_reg_write && mem_wreg != 5'd0 && mem_wreg == r) return mem_result;
    if (wb_reg_write && wb_wreg != 5'd0 && wb_wreg == r) return wb_result;
    return v;
  endfunction

  always @(posedge clk) begin
    lu_p = lu_of(m_valid, m_mr, m_wreg);
    if (!rst_n) begin
      {m_valid, m_src, m_rw, m_mr, m_mw, m_m2r} = '0;
      {m_rs, m_rt, m_shamt, m_wreg, m_op} = '0;
      {m_rs_val, m_rt_val, m_imm} = '0;
    end else if (flush || lu_p) begin
      {m_valid, m_rw, m_mr, m_mw, m_m2r} = '0;
    end else begin
      m_valid = id_valid; m_rs = id_rs; m_rt = id_rt;
      m_rs_val = id_rs_val; m_rt_val = id_rt_val; m_imm = id_imm;
      m_shamt = id_shamt; m_op = id_alu_op; m_src = id_alu_src; m_wreg = id_wreg;
      m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write; m_m2r = id_mem_to_reg;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      lu_n = lu_of(m_valid, m_mr, m_wreg);
      chk("m.stall", 32'(stall), 32'(lu_n && !flush));
      chk("m.ex_valid", 32'(ex_valid), 32'(m_valid));
      chk("m.reg_write", 32'(ex_reg_write), 32'(m_valid && m_rw));
      chk("m.mem_read", 32'(ex_mem_read), 32'(m_valid && m_mr));
      chk("m.mem_write", 32'(ex_mem_write), 32'(m_valid && m_mw));
      chk("m.mem_to_reg", 32'(ex_mem_to_reg), 32'(m_valid && m_m2r));
      if (m_valid) begin
        chk("m.alu_a", alu_a, fwd(m_rs, m_rs_val));
        chk("m.alu_b", alu_b, m_src ? m_imm : fwd(m_rt, m_rt_val));
        chk("m.store_data", ex_store_data, fwd(m_rt, m_rt_val));
        chk("m.shamt", 32'(alu_shamt), 32'(m_shamt));
        chk("m.alu_op", 32'(alu_op), 32'(m_op));
        chk("m.wreg", 32'(ex_wreg), 32'(m_wreg));
      end
    end
  end

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt,
                        input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] imm,
                        input logic [4:0] sh, input logic [3:0] op, input logic src,
                        input logic [4:0] wr, input logic rw, input logic mr,
                        input logic mw, input logic m2r);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_rs_val = rsv; id_rt_val = rtv; id_imm = imm; id_shamt = sh; id_alu_op = op;
    id_alu_src = src; id_wreg = wr; id_reg_write = rw; id_mem_read = mr;
    id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  task automatic id_nop();
    id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 4'd0, 1'b0,
           5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fwd_clear();
    mem_reg_write = 1'b0; mem_wreg = 5'd0; mem_result = 32'd0;
    wb_reg_write = 1'b0; wb_wreg = 5'd0; wb_result = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lw $4,0($1)
  task automatic id_lw4();
    id_set(1'b1, 5'd1, 5'd4, 1'b1, 1'b0, 32'h100, 32'd0, 32'd0, 5'd0, 4'h2, 1'b1,
           5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  // subu $5,$4,$2
  task automatic id_subu5();
    id_set(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 32'h0, 32'd9, 32'd0, 5'd0, 4'h3, 1'b0,
           5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    id_nop(); fwd_clear();
    tick(); tick();
    #2;
    chk("rst.ex_valid", 32'(ex_valid), 32'd0);
    chk("rst.alu_a", alu_a, 32'd0);
    chk("rst.alu_b", alu_b, 32'd0);
    chk("rst.store", ex_store_data, 32'd0);
    chk("rst.ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);

    // addu $3,$1,$2
    rst_n = 1'b1;
    id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 32'd5, 32'd7, 32'd0, 5'd0, 4'h1, 1'b0,
           5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id_nop();
    #2;
    chk("addu.alu_a", alu_a, 32'd5);
    chk("addu.alu_b", alu_b, 32'd7);
    chk("addu.ex_valid", 32'(ex_valid), 32'd1);
    chk("addu.reg_write", 32'(ex_reg_write), 32'd1);
    chk("addu.wreg", 32'(ex_wreg), 32'd3);

    // Forwarding on rs=1
    id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 32'd3, 32'd4, 32'd0, 5'd0, 4'h1, 1'b0,
           5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id_nop();
    mem_reg_write = 1'b1; mem_wreg = 5'd1; mem_result = 32'h10;
    #1 chk("fwd.mem", alu_a, 32'h10);
    wb_reg_write = 1'b1; wb_wreg = 5'd1; wb_result = 32'h20;
    #1 chk("fwd.mem_prio", alu_a, 32'h10);
    mem_reg_write = 1'b0;
    #1 chk("fwd.wb", alu_a, 32'h20);
    wb_wreg = 5'd2;
    #1 chk("fwd.wb_rt", alu_b, 32'h20);
    chk("fwd.wb_store", ex_store_data, 32'h20);
    fwd_clear();

    // Register 0 never forwarded
    id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0, 5'd0, 4'h1, 1'b0,
           5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id_nop();
    mem_reg_write = 1'b1; mem_wreg = 5'd0; mem_result = 32'hFFFF;
    wb_reg_write = 1'b1; wb_wreg = 5'd0; wb_result = 32'h1234;
    #1 chk("r0.alu_a", alu_a, 32'd0);
    chk("r0.alu_b", alu_b, 32'd0);
    fwd_clear();

    // Load-use: one stall cycle, then WB forward
    id_lw4();
    tick();
    id_subu5();
    #2;
    chk("lu.stall", 32'(stall), 32'd1);
    chk("lu.ex_mem_read", 32'(ex_mem_read), 32'd1);
    tick();
    #2;
    chk("lu.bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu.stall_once", 32'(stall), 32'd0);
    tick();
    id_nop();
    wb_reg_write = 1'b1; wb_wreg = 5'd4; wb_result = 32'hABCD;
    #2;
    chk("lu.consumer_valid", 32'(ex_valid), 32'd1);
    chk("lu.alu_a", alu_a, 32'hABCD);
    chk("lu.alu_b", alu_b, 32'd9);
    fwd_clear();

    // Dependent indices with id_valid=0 never stall
    id_lw4();
    tick();
    id_subu5();
    id_valid = 1'b0;
    #2 chk("nv.stall", 32'(stall), 32'd0);

    // Flush and load-use together
    id_lw4();
    tick();
    id_subu5();
    flush = 1'b1;
    #2 chk("fl.stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0;
    id_nop();
    #2;
    chk("fl.ex_valid", 32'(ex_valid), 32'd0);
    chk("fl.ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'd0);

    // Immediate operand and shift amount
    id_set(1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 32'd0, 32'h55, 32'hFFFF_FFFC, 5'd2, 4'h8, 1'b1,
           5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id_nop();
    #2;
    chk("imm.alu_b", alu_b, 32'hFFFF_FFFC);
    chk("imm.store", ex_store_data, 32'h55);
    chk("imm.shamt", 32'(alu_shamt), 32'd2);
    chk("imm.alu_op", 32'(alu_op), 32'h8);
    rst_n = 1'b0;
    tick();
    #2;
    chk("mrst.ex_valid", 32'(ex_valid), 32'd0);
    chk("mrst.alu_b", alu_b, 32'd0);
    chk("mrst.shamt", 32'(alu_shamt), 32'd0);
    chk("mrst.alu_op", 32'(alu_op), 32'd0);
    chk("mrst.wreg", 32'(ex_wreg), 32'd0);
    rst_n = 1'b1;

    // Reset during a stall cancels it
    id_lw4();
    tick();
    id_subu5();
    #2 chk("rs.stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    tick();
    #2;
    chk("rs.stall_cleared", 32'(stall), 32'd0);
    chk("rs.ex_valid", 32'(ex_valid), 32'd0);
    rst_n = 1'b1;
    id_nop();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
